// File: rtl/card_pkg.sv
// Shared types and helpers for the card dealer: deck constants, FSM state,
// card struct and the lfsr/rank mapping functions.
package card_pkg;

    localparam int DECK_SIZE = 52;
    localparam int RANKS     = 13;
    localparam int SUITS     = 4;
    localparam int LFSR_BITS = 8;

    localparam logic [3:0] RANK_ACE   = 4'd1;
    localparam logic [3:0] ACE_VALUE  = 4'd11;
    localparam logic [3:0] FACE_VALUE = 4'd10;

    typedef enum logic {
        IDLE  = 1'b0,
        PROBE = 1'b1
    } state_e;

    typedef struct packed {
        logic [1:0] suit;
        logic [3:0] rank;
    } card_t;

    function automatic logic [3:0] rank_to_value(input logic [3:0] rank);
        if (rank == RANK_ACE)
            return ACE_VALUE;
        else if (rank > 4'd10)
            return FACE_VALUE;
        else
            return rank;
    endfunction

    // Out-of-range rank codes fold onto low ranks so every lfsr value names a card.
    function automatic card_t lfsr_to_card(input logic [LFSR_BITS-1:0] v);
        card_t c;
        c.suit = v[5:4];
        case (v[3:0])
            4'd0, 4'd14: c.rank = 4'd1;
            4'd15:       c.rank = 4'd2;
            default:     c.rank = v[3:0];
        endcase
        return c;
    endfunction

    function automatic logic [5:0] card_index(input card_t c);
        return 6'(c.suit) * 6'(RANKS) + 6'(c.rank) - 6'd1;
    endfunction

    function automatic card_t next_card(input card_t c);
        card_t n;
        if (c.rank == 4'(RANKS)) begin
            n.rank = RANK_ACE;
            n.suit = c.suit + 2'd1;
        end else begin
            n.rank = c.rank + 4'd1;
            n.suit = c.suit;
        end
        return n;
    endfunction

endpackage

// File: rtl/card_lfsr.sv
// Free-running Fibonacci LFSR, x^8+x^6+x^5+x^4+1, with a loadable seed.
// A zero load value is replaced by SEED so the register never locks up.
module card_lfsr #(
    parameter int              W    = 8,
    parameter logic [W-1:0]    SEED = 8'hA5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;
    logic         fb;

    always_comb begin
        fb = q_q[W-1] ^ q_q[W-3] ^ q_q[W-4] ^ q_q[W-5];
        if (load)
            q_d = (load_val == '0) ? SEED : load_val;
        else
            q_d = {q_q[W-2:0], fb};
    end

    always_ff @(posedge clk) begin
        if (rst)
            q_q <= SEED;
        else
            q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/card_dealer.sv
// Card dealer: lfsr start point plus linear probe over a 52-bit dealt bitmap.
// Define DEAL_SEED_EN to add a seed port that reloads the lfsr on shuffle.
module card_dealer
    import card_pkg::*;
#(
    parameter int                 LFSR_W     = 8,
    parameter logic [LFSR_W-1:0]  RESET_SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shuffle,
    input  logic              req,
`ifdef DEAL_SEED_EN
    input  logic [LFSR_W-1:0] seed,
`endif
    output logic              card_valid,
    output logic [1:0]        card_suit,
    output logic [3:0]        card_rank,
    output logic [3:0]        card_value,
    output logic [5:0]        cards_left,
    output logic              deck_empty,
    output logic              busy,
    output logic              req_err
);

    state_e                 state_q, state_d;
    card_t                  cand_q, cand_d;
    card_t                  card_q, card_d;
    logic [DECK_SIZE-1:0]   dealt_q, dealt_d;
    logic [5:0]             cards_left_q, cards_left_d;
    logic                   deck_empty_q, deck_empty_d;
    logic [3:0]             card_value_q, card_value_d;
    logic                   card_valid_q, card_valid_d;
    logic                   req_err_q, req_err_d;
    logic [LFSR_W-1:0]      lfsr;
    logic                   lfsr_load;
    logic [LFSR_W-1:0]      lfsr_load_val;
    logic [5:0]             cand_idx;

`ifdef DEAL_SEED_EN
    assign lfsr_load     = shuffle;
    assign lfsr_load_val = seed;
`else
    // Without a seed port shuffle leaves the lfsr running undisturbed.
    assign lfsr_load     = 1'b0;
    assign lfsr_load_val = '0;
`endif

    card_lfsr #(
        .W    (LFSR_W),
        .SEED (RESET_SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (lfsr_load),
        .load_val (lfsr_load_val),
        .q        (lfsr)
    );

    assign cand_idx = card_index(cand_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cand_q       <= '0;
            card_q       <= '0;
            dealt_q      <= '0;
            cards_left_q <= 6'(DECK_SIZE);
            deck_empty_q <= 1'b0;
            card_value_q <= '0;
            card_valid_q <= 1'b0;
            req_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            card_q       <= card_d;
            dealt_q      <= dealt_d;
            cards_left_q <= cards_left_d;
            deck_empty_q <= deck_empty_d;
            card_value_q <= card_value_d;
            card_valid_q <= card_valid_d;
            req_err_q    <= req_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        card_d       = card_q;
        dealt_d      = dealt_q;
        cards_left_d = cards_left_q;
        deck_empty_d = deck_empty_q;
        card_value_d = card_value_q;
        card_valid_d = 1'b0;
        req_err_d    = 1'b0;

        if (shuffle) begin
            state_d      = IDLE;
            dealt_d      = '0;
            cards_left_d = 6'(DECK_SIZE);
            deck_empty_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        if (deck_empty_q) begin
                            req_err_d = 1'b1;
                        end else begin
                            cand_d  = lfsr_to_card(lfsr);
                            state_d = PROBE;
                        end
                    end
                end
                PROBE: begin
                    if (!dealt_q[cand_idx]) begin
                        dealt_d[cand_idx] = 1'b1;
                        card_d            = cand_q;
                        card_value_d      = rank_to_value(cand_q.rank);
                        card_valid_d      = 1'b1;
                        cards_left_d      = cards_left_q - 6'd1;
                        deck_empty_d      = (cards_left_q == 6'd1);
                        state_d           = IDLE;
                    end else begin
                        cand_d = next_card(cand_q);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = (state_q == PROBE);
        card_valid = card_valid_q;
        card_suit  = card_q.suit;
        card_rank  = card_q.rank;
        card_value = card_value_q;
        cards_left = cards_left_q;
        deck_empty = deck_empty_q;
        req_err    = req_err_q;
    end

endmodule

// File: tb/tb_card_dealer.sv
// Directed self-checking bench for card_dealer; seed-port tests run only
// when DEAL_SEED_EN is defined.
module tb_card_dealer;

    logic       clk = 1'b0;
    logic       rst;
    logic       shuffle;
    logic       req;
`ifdef DEAL_SEED_EN
    logic [7:0] seed;
`endif
    logic       card_valid;
    logic [1:0] card_suit;
    logic [3:0] card_rank;
    logic [3:0] card_value;
    logic [5:0] cards_left;
    logic       deck_empty;
    logic       busy;
    logic       req_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    card_dealer dut (
        .clk        (clk),
        .rst        (rst),
        .shuffle    (shuffle),
        .req        (req),
`ifdef DEAL_SEED_EN
        .seed       (seed),
`endif
        .card_valid (card_valid),
        .card_suit  (card_suit),
        .card_rank  (card_rank),
        .card_value (card_value),
        .cards_left (cards_left),
        .deck_empty (deck_empty),
        .busy       (busy),
        .req_err    (req_err)
    );

    function automatic logic [3:0] exp_value(input logic [3:0] rank);
        if (rank == 4'd1) return 4'd11;
        if (rank >= 4'd11) return 4'd10;
        return rank;
    endfunction

    task automatic do_reset();
        rst = 1'b1; shuffle = 1'b0; req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic issue_req(output logic got, output logic [1:0] s,
                             output logic [3:0] r, output logic [3:0] v,
                             output int lat);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        got = 1'b0; s = '0; r = '0; v = '0; lat = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (card_valid) begin
                got = 1'b1; s = card_suit; r = card_rank; v = card_value;
            end
        end
    endtask

    task automatic deal_n(input int n);
        logic got; logic [1:0] s; logic [3:0] r, v; int lat;
        for (int i = 0; i < n; i++) begin
            issue_req(got, s, r, v, lat);
            n_checks++;
            if (got !== 1'b1) begin
                n_fail++; $display("FAIL deal_n_timeout: card %0d got no card_valid", i);
            end
        end
    endtask

    task automatic check_card(input string name, input logic got, input logic [1:0] s,
                              input logic [3:0] r, input logic [3:0] v,
                              input logic [1:0] es, input logic [3:0] er, input logic [3:0] ev);
        n_checks++;
        if (got !== 1'b1 || s !== es || r !== er || v !== ev) begin
            n_fail++;
            $display("FAIL %s: got valid=%0b suit=%0d rank=%0d value=%0d, expected suit=%0d rank=%0d value=%0d",
                     name, got, s, r, v, es, er, ev);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (cards_left !== 6'd52 || deck_empty !== 1'b0 || busy !== 1'b0 || card_valid !== 1'b0 ||
            card_suit !== 2'd0 || card_rank !== 4'd0 || card_value !== 4'd0 || req_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: left=%0d empty=%0b busy=%0b valid=%0b suit=%0d rank=%0d value=%0d err=%0b",
                     cards_left, deck_empty, busy, card_valid, card_suit, card_rank, card_value, req_err);
        end
    endtask

    // lfsr from reset: A5,4A,95,2A,54,A9,53,A7,4E,9D
    task automatic test_reset_seed_deal();
        logic got; logic [1:0] s; logic [3:0] r, v; int lat;
        do_reset();
        issue_req(got, s, r, v, lat);
        check_card("first_deal_a5", got, s, r, v, 2'd2, 4'd5, 4'd5);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL first_deal_latency: got %0d expected 1", lat); end
        n_checks++;
        if (cards_left !== 6'd51) begin n_fail++; $display("FAIL first_deal_left: got %0d expected 51", cards_left); end
        @(negedge clk);
        n_checks++;
        if (card_valid !== 1'b0 || card_suit !== 2'd2 || card_rank !== 4'd5 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_pulse_hold: valid=%0b suit=%0d rank=%0d busy=%0b, expected 0/2/5/0",
                     card_valid, card_suit, card_rank, busy);
        end
    endtask

    task automatic test_values();
        logic got; logic [1:0] s; logic [3:0] r, v; int lat;
        do_reset();
        repeat (1) @(negedge clk);
        issue_req(got, s, r, v, lat);
        check_card("ten_4a", got, s, r, v, 2'd0, 4'd10, 4'd10);
        do_reset();
        repeat (8) @(negedge clk);
        issue_req(got, s, r, v, lat);
        check_card("ace_4e", got, s, r, v, 2'd0, 4'd1, 4'd11);
        do_reset();
        repeat (9) @(negedge clk);
        issue_req(got, s, r, v, lat);
        check_card("king_9d", got, s, r, v, 2'd1, 4'd13, 4'd10);
    endtask

    task automatic test_full_deck();
        logic got; logic [1:0] s; logic [3:0] r, v; int lat;
        logic [51:0] seen;
        int sum, n_got, idx;
        logic saw_valid;
        do_reset();
        seen = '0; sum = 0; n_got = 0;
        for (int i = 0; i < 52; i++) begin
            issue_req(got, s, r, v, lat);
            n_checks++;
            if (got !== 1'b1 || r < 4'd1 || r > 4'd13) begin
                n_fail++; $display("FAIL deck_card_%0d: valid=%0b rank=%0d", i, got, r);
            end else begin
                idx = int'(s) * 13 + int'(r) - 1;
                n_checks++;
                if (seen[idx] !== 1'b0) begin
                    n_fail++; $display("FAIL deck_repeat: suit=%0d rank=%0d dealt twice", s, r);
                end
                seen[idx] = 1'b1;
                n_checks++;
                if (v !== exp_value(r)) begin
                    n_fail++; $display("FAIL deck_value: rank=%0d got %0d expected %0d", r, v, exp_value(r));
                end
                sum += int'(v);
                n_got++;
            end
            n_checks++;
            if (cards_left !== 6'(51 - i)) begin
                n_fail++; $display("FAIL deck_left: got %0d expected %0d", cards_left, 51 - i);
            end
        end
        n_checks++;
        if (n_got !== 52 || sum !== 380) begin
            n_fail++; $display("FAIL deck_sum: cards=%0d sum=%0d expected 52/380", n_got, sum);
        end
        n_checks++;
        if (cards_left !== 6'd0 || deck_empty !== 1'b1) begin
            n_fail++; $display("FAIL deck_empty: left=%0d empty=%0b expected 0/1", cards_left, deck_empty);
        end
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        n_checks++;
        if (req_err !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL empty_req_err: err=%0b busy=%0b expected 1/0", req_err, busy);
        end
        saw_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_err !== 1'b0) begin n_fail++; $display("FAIL req_err_pulse: got %0b expected 0", req_err); end
        repeat (5) begin
            if (card_valid) saw_valid = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL empty_no_card: got valid=1 expected none"); end
    endtask

    task automatic test_shuffle_priority();
        logic saw_valid;
        do_reset();
        deal_n(51);
        n_checks++;
        if (cards_left !== 6'd1) begin n_fail++; $display("FAIL prio_setup_left: got %0d expected 1", cards_left); end
        req = 1'b1; shuffle = 1'b1;
        @(negedge clk);
        req = 1'b0; shuffle = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || cards_left !== 6'd52 || deck_empty !== 1'b0 || card_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL shuffle_priority: busy=%0b left=%0d empty=%0b valid=%0b expected 0/52/0/0",
                     busy, cards_left, deck_empty, card_valid);
        end
        saw_valid = 1'b0;
        repeat (55) begin
            @(negedge clk);
            if (card_valid) saw_valid = 1'b1;
        end
        n_checks++;
        if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL prio_no_card: got valid=1 expected none"); end
    endtask

    task automatic test_abort_reset();
        logic got; logic [1:0] s; logic [3:0] r, v; int lat;
        logic saw_valid;
        do_reset();
        deal_n(51);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_rst_busy: got %0b expected 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        saw_valid = card_valid;
        n_checks++;
        if (cards_left !== 6'd52 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_rst_state: left=%0d busy=%0b expected 52/0", cards_left, busy);
        end
        repeat (3) begin
            @(negedge clk);
            if (card_valid) saw_valid = 1'b1;
        end
        n_checks++;
        if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL abort_rst_no_card: got valid=1 expected none"); end
        // lfsr restarted at A5, three advances -> 2A
        issue_req(got, s, r, v, lat);
        check_card("abort_rst_lfsr_2a", got, s, r, v, 2'd2, 4'd10, 4'd10);
    endtask

    task automatic test_abort_shuffle();
        logic saw_valid;
        do_reset();
        deal_n(51);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_shf_busy: got %0b expected 1", busy); end
        shuffle = 1'b1;
        @(negedge clk);
        shuffle = 1'b0;
        saw_valid = card_valid;
        n_checks++;
        if (cards_left !== 6'd52 || busy !== 1'b0 || deck_empty !== 1'b0) begin
            n_fail++; $display("FAIL abort_shf_state: left=%0d busy=%0b empty=%0b expected 52/0/0",
                               cards_left, busy, deck_empty);
        end
        repeat (55) begin
            @(negedge clk);
            if (card_valid) saw_valid = 1'b1;
        end
        n_checks++;
        if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL abort_shf_no_card: got valid=1 expected none"); end
    endtask

`ifdef DEAL_SEED_EN
    task automatic test_seed_deal();
        logic got; logic [1:0] s; logic [3:0] r, v; int lat;
        logic [7:0]  seeds [4] = '{8'h25, 8'h1C, 8'h0E, 8'h00};
        logic [1:0]  es    [4] = '{2'd2, 2'd1, 2'd0, 2'd2};
        logic [3:0]  er    [4] = '{4'd5, 4'd12, 4'd1, 4'd5};
        logic [3:0]  ev    [4] = '{4'd5, 4'd10, 4'd11, 4'd5};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            seed = seeds[i];
            shuffle = 1'b1;
            @(negedge clk);
            shuffle = 1'b0;
            issue_req(got, s, r, v, lat);
            check_card($sformatf("seed_%02h", seeds[i]), got, s, r, v, es[i], er[i], ev[i]);
            n_checks++;
            if (cards_left !== 6'd51) begin
                n_fail++; $display("FAIL seed_left: got %0d expected 51", cards_left);
            end
        end
    endtask
`endif

    initial begin
        rst = 1'b1; shuffle = 1'b0; req = 1'b0;
`ifdef DEAL_SEED_EN
        seed = 8'h00;
`endif
        test_reset();
        test_reset_seed_deal();
        test_values();
        test_full_deck();
        test_shuffle_priority();
        test_abort_reset();
        test_abort_shuffle();
`ifdef DEAL_SEED_EN
        test_seed_deal();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
